// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: main + skid entry with valid/ready backpressure,
// synchronous flush with bubble insertion, and saturating stall/flush-drop counters.
module pipe_stage_elastic #(
  parameter int unsigned DATA_W     = 96,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter bit          CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_drops
);

  typedef enum logic [1:0] {StEmpty, StFull1, StFull2} state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [CNT_W-1:0]  stall_q, drops_q;

  logic        main_valid, skid_valid;
  logic        in_fire, out_fire;
  logic [1:0]  drop_n;
  logic [CNT_W:0] drops_sum;

  always_comb begin
    main_valid = (state_q != StEmpty);
    skid_valid = (state_q == StFull2);
    // Skid occupancy is registered, so in_ready never depends on out_ready.
    in_ready   = !rst && !flush && (state_q != StFull2);
    out_valid  = main_valid;
    out_ctrl   = out_valid ? main_ctrl_q : '0;
    out_data   = main_data_q;
    occupancy  = {main_valid & skid_valid, main_valid ^ skid_valid};
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    // A head consumed during the flush cycle is delivered, not dropped.
    drop_n     = occupancy - {1'b0, out_fire};
    drops_sum  = {1'b0, drops_q} + (CNT_W + 1)'(drop_n);
  end

  assign stall_cycles = stall_q;
  assign flush_drops  = drops_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      main_data_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
      drops_q     <= '0;
    end else if (flush) begin
      state_q     <= StEmpty;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      if (CLEAR_DATA) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end
      drops_q <= drops_sum[CNT_W] ? '1 : drops_sum[CNT_W-1:0];
    end else begin
      if (out_valid && !out_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
            state_q     <= StFull1;
          end
        end
        StFull1: begin
          if (in_fire && out_fire) begin
            main_ctrl_q <= in_ctrl;
            main_data_q <= in_data;
          end else if (in_fire) begin
            skid_ctrl_q <= in_ctrl;
            skid_data_q <= in_data;
            state_q     <= StFull2;
          end else if (out_fire) begin
            main_ctrl_q <= '0;
            state_q     <= StEmpty;
          end
        end
        StFull2: begin
          if (out_fire) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
            state_q     <= StFull1;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: two instances (data-clearing 4-bit counters, data-holding
// 16-bit counters) driven identically and compared against a queue-based reference model.
module tb_pipe_stage_elastic;

  localparam int DW = 96;
  localparam int CW = 8;

  logic          clk, rst, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [CW-1:0] out_ctrl_a, out_ctrl_b;
  logic [DW-1:0] out_data_a, out_data_b;
  logic [1:0]    occ_a, occ_b;
  logic [3:0]    stall_a, drops_a;
  logic [15:0]   stall_b, drops_b;

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4), .CLEAR_DATA(1'b1)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ctrl(out_ctrl_a), .out_data(out_data_a), .occupancy(occ_a),
    .stall_cycles(stall_a), .flush_drops(drops_a)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16), .CLEAR_DATA(1'b0)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(out_ctrl_b), .out_data(out_data_b), .occupancy(occ_b),
    .stall_cycles(stall_b), .flush_drops(drops_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] m_data_a, m_data_b;
  int            m_stall_a, m_stall_b, m_drops_a, m_drops_b;
  int            errors = 0;
  int            checks = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data_a = '0;
    m_data_b = '0;
    m_stall_a = 0;
    m_stall_b = 0;
    m_drops_a = 0;
    m_drops_b = 0;
  endtask

  task automatic check_all();
    logic          v;
    logic [CW-1:0] c;
    logic          ir;
    v  = (q.size() > 0);
    c  = v ? q[0].c : '0;
    ir = !rst && !flush && (q.size() < 2);
    chk("in_ready_a", in_ready_a, ir);
    chk("in_ready_b", in_ready_b, ir);
    chk("out_valid_a", out_valid_a, v);
    chk("out_valid_b", out_valid_b, v);
    chk("out_ctrl_a", out_ctrl_a, c);
    chk("out_ctrl_b", out_ctrl_b, c);
    chk("out_data_a", out_data_a, v ? q[0].d : m_data_a);
    chk("out_data_b", out_data_b, v ? q[0].d : m_data_b);
    chk("occupancy_a", occ_a, q.size());
    chk("occupancy_b", occ_b, q.size());
    chk("stall_a", stall_a, m_stall_a);
    chk("stall_b", stall_b, m_stall_b);
    chk("drops_a", drops_a, m_drops_a);
    chk("drops_b", drops_b, m_drops_b);
  endtask

  // One clock: drive after the falling edge, check before the rising edge, advance model.
  task automatic cycle(input logic iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy, input logic fl);
    logic of, inf;
    ent_t e;
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    #1;
    check_all();
    of  = (q.size() > 0) && ordy;
    inf = iv && !fl && (q.size() < 2);
    @(posedge clk);
    if (fl) begin
      m_drops_a = sat(m_drops_a + q.size() - int'(of), 15);
      m_drops_b = sat(m_drops_b + q.size() - int'(of), 65535);
      q.delete();
      m_data_a = '0;
    end else begin
      if (q.size() > 0 && !ordy) begin
        m_stall_a = sat(m_stall_a + 1, 15);
        m_stall_b = sat(m_stall_b + 1, 65535);
      end
      if (of) void'(q.pop_front());
      if (inf) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
      if (q.size() > 0) begin
        m_data_a = q[0].d;
        m_data_b = q[0].d;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst = 1'b0;

    // Streaming with downstream always ready.
    for (int i = 1; i <= 4; i++) cycle(1'b1, CW'(8'h10 + i), DW'(i), 1'b1, 1'b0);
    chk("stream_head", out_data_a, 96'd4);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("stream_stall", stall_b, 16'd0);

    // Backpressure fills the skid entry, then drains in order.
    cycle(1'b1, 8'hA1, 96'hAAAA, 1'b0, 1'b0);
    cycle(1'b1, 8'hB2, 96'hBBBB, 1'b0, 1'b0);
    repeat (2) cycle(1'b1, 8'hCC, 96'hCCCC, 1'b0, 1'b0);
    chk("bp_occ", occ_a, 2'd2);
    repeat (3) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with both entries held and nothing consumed.
    cycle(1'b1, 8'h31, 96'h3131, 1'b0, 1'b0);
    cycle(1'b1, 8'h32, 96'h3232, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 96'h3333, 1'b0, 1'b1);
    chk("flush2_drops", drops_a, 4'd2);
    chk("flush2_data", out_data_a, 96'd0);
    cycle(1'b0, '0, '0, 1'b0, 1'b0);

    // Flush with one entry consumed in the same cycle.
    cycle(1'b1, 8'h44, 96'h4444, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b1);
    chk("flush1_drops", drops_b, 16'd2);
    chk("flush1_hold", out_data_b, 96'h4444);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with two entries stored.
    cycle(1'b1, 8'h55, 96'h5555, 1'b0, 1'b0);
    cycle(1'b1, 8'h66, 96'h6666, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid_a, 1'b0);
    chk("arst_ctrl", out_ctrl_b, 8'd0);
    chk("arst_data", out_data_b, 96'd0);
    chk("arst_occ", occ_a, 2'd0);
    chk("arst_ready", in_ready_a, 1'b0);
    chk("arst_stall", stall_b, 16'd0);
    chk("arst_drops", drops_b, 16'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Stall counter saturation on the 4-bit instance.
    cycle(1'b1, 8'h77, 96'h7777, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, '0, '0, 1'b0, 1'b0);
    chk("sat_stall_a", stall_a, 4'd15);
    chk("sat_stall_b", stall_b, 16'd20);
    repeat (2) cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, CW'($urandom), {$urandom, $urandom, $urandom},
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
Parametrised elastic pipeline-stage register for the ARM pipeline, a generalisation of the fixed stage registers (ID/EX etc.).
- Carries a CTRL_W-bit control bundle (WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, …) and a DATA_W-bit data bundle (PC, Val_Rn, Val_Rm, immediates, Dest, SR, …).
- Adds valid/ready backpressure through a 2-entry skid buffer, synchronous flush with bubble insertion, and stall/flush performance counters.
- Sits between any two stages: upstream is the producer, downstream is the consumer.

Parameters:
- DATA_W, 96, width of data bundle.
- CTRL_W, 8, width of control bundle; forced to zero when output is not valid.
- CNT_W, 16, width of each saturating performance counter.
- CLEAR_DATA, 1, 1 = flush zeroes stored data; 0 = flush leaves stored data unchanged.

Ports:
- clk, input, 1, clock, rising edge.
- rst, input, 1, reset, asynchronous, active-high.
- flush, input, 1, synchronous flush (branch taken / hazard kill).
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W, upstream control bundle.
- in_data, input, DATA_W, upstream data bundle.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, downstream accepts head this cycle.
- out_ctrl, output, CTRL_W, head control; zero when out_valid=0.
- out_data, output, DATA_W, head data; holds last value when invalid.
- occupancy, output, 2, stored entries (0..2).
- stall_cycles, output, CNT_W, cycles with out_valid=1 and out_ready=0.
- flush_drops, output, CNT_W, entries discarded by flush.

Behaviour:
- Storage: main register (drives outputs) and skid register, each holding ctrl, data and valid.
- Reset (async, rst=1):
  - State EMPTY; both registers' ctrl/data/valid = 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cycles=0, flush_drops=0.
  - in_ready=0 while rst is high.
  - Reset mid-transfer discards everything; no partial state survives.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = !rst & !flush & (state != FULL2). The skid bit is registered, so in_ready does not depend on out_ready.
  - out_valid = (state != EMPTY). out_ctrl = main_ctrl gated by out_valid.
  - Latency: 1 cycle from in_fire to out_valid when EMPTY.
  - Throughput: 1 entry/cycle with out_ready held high.
- State machine (flush=0):
  - EMPTY: in_fire → main<=in, FULL1; else stay.
  - FULL1, in_fire & out_fire: main<=in, stay FULL1.
  - FULL1, in_fire & !out_fire: skid<=in, FULL2.
  - FULL1, !in_fire & out_fire: EMPTY; main_ctrl<=0, main_data held.
  - FULL1, no fire: hold.
  - FULL2: in_ready=0. out_fire → main<=skid, skid_ctrl<=0, FULL1; else hold.
  - Ordering is FIFO; entries are never reordered or duplicated.
- Flush (highest priority after rst):
  - Next state EMPTY; main_ctrl and skid_ctrl <= 0.
  - Data <= 0 if CLEAR_DATA=1, else held.
  - in_ready=0 that cycle, so no upstream entry is lost.
  - out_fire in the flush cycle is honoured: downstream keeps that head.
  - flush_drops += occupancy − (out_fire ? 1 : 0), saturating.
  - Flush while EMPTY is a no-op apart from asserting in_ready=0.
- Counters:
  - stall_cycles += 1 each cycle with out_valid & !out_ready & !flush.
  - Both counters saturate at 2^CNT_W−1; cleared only by rst.
- Width rules:
  - Bundles pass through bit-exact.
  - occupancy = {main_valid & skid_valid, main_valid ^ skid_valid}-encoded count (0, 1, 2).

Test Plan:
- Reset then stream: in_valid=1 for 4 cycles, in_data=1..4, out_ready=1 → out_data=1..4 on consecutive cycles starting 1 cycle after the first in_fire; occupancy stays 1; stall_cycles=0.
- Backpressure: out_ready=0, push A, B → occupancy=2, in_ready=0, out_data=A, stall_cycles increments per cycle; then out_ready=1 → A, then B, then out_valid=0 with out_ctrl=0.
- Flush at occupancy=2 with out_ready=0 and CLEAR_DATA=1 → next cycle occupancy=0, out_ctrl=0, out_data=0, flush_drops=2; in_ready=0 during the flush cycle.
- Flush at occupancy=1 with out_ready=1 → head consumed, flush_drops unchanged; with CLEAR_DATA=0 → out_data holds its last value.
- Async rst asserted mid-cycle at occupancy=2 → outputs zero immediately, before the next clk edge; counters=0.
- Saturation with CNT_W=4: hold out_ready=0 for 20 cycles → stall_cycles=15 and stays 15.
